// File: rtl/ucode_sequencer.sv
// Microprogram sequencer: a two-phase uPC walk over a synchronous micro-ROM.
// Each microword carries its own next-address control, so micro-sequences can vary in length.
module ucode_sequencer #(
  parameter int INSTR_W = 16,
  parameter int UADDR_W = 8,
  parameter int CTRL_W = 24,
  parameter int FETCH_ADDR = 2,
  parameter int IRQ_VECTOR = 1,
  parameter int FAULT_VECTOR = 0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFE00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INSTR_W-1:0]          instr,
  input  logic                        cond_in,
  input  logic                        stall,
  input  logic                        irq,
  input  logic                        fault,
  output logic [UADDR_W-1:0]          rom_addr,
  input  logic [CTRL_W+UADDR_W+2:0]   rom_data,
  output logic [CTRL_W-1:0]           ctrl,
  output logic                        ctrl_valid,
  output logic [UADDR_W-1:0]          upc,
  output logic                        phase,
  output logic                        irq_ack,
  output logic                        halted
);

  localparam logic [UADDR_W-1:0] FETCH_A = UADDR_W'(FETCH_ADDR);
  localparam logic [UADDR_W-1:0] IRQ_A   = UADDR_W'(IRQ_VECTOR);
  localparam logic [UADDR_W-1:0] FAULT_A = UADDR_W'(FAULT_VECTOR);

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_DISPATCH = 3'd2;
  localparam logic [2:0] OP_CJUMP    = 3'd3;
  localparam logic [2:0] OP_END      = 3'd4;
  localparam logic [2:0] OP_HALT     = 3'd5;

  typedef enum logic {PH_A, PH_B} phase_t;

  phase_t               state, state_next;
  logic [UADDR_W-1:0]   upc_next;
  logic                 halted_next;
  logic                 irq_pend, irq_pend_next;
  logic                 ack;
  logic [UADDR_W-1:0]   naddr;
  logic [2:0]           seqop;
  logic [UADDR_W-1:0]   upc_inc;

  // Short opcodes use two bits below the MSB, long opcodes use six.
  function automatic logic [UADDR_W-1:0] opcode_of(input logic [INSTR_W-1:0] ir);
    logic [5:0] op;
    if (ir[INSTR_W-1])
      op = ir[INSTR_W-2:INSTR_W-7];
    else
      op = {4'b0, ir[INSTR_W-2:INSTR_W-3]};
    return UADDR_W'(op);
  endfunction

  assign naddr   = rom_data[UADDR_W-1:0];
  assign seqop   = rom_data[UADDR_W+2:UADDR_W];
  assign upc_inc = upc + 1'b1;

  always_comb begin
    state_next    = state;
    upc_next      = upc;
    halted_next   = halted;
    irq_pend_next = irq_pend;
    ack           = 1'b0;
    if (halted) begin
      state_next = state;
    end else if (fault) begin
      upc_next   = FAULT_A;
      state_next = PH_A;
    end else if (state == PH_A) begin
      state_next = PH_B;
    end else if (!stall) begin
      state_next = PH_A;
      case (seqop)
        OP_JUMP:     upc_next = naddr;
        OP_DISPATCH: begin
          if (instr == HALT_INSTR) begin
            halted_next = 1'b1;
            state_next  = PH_B;
          end else begin
            upc_next = naddr + opcode_of(instr);
          end
        end
        OP_CJUMP:    upc_next = cond_in ? naddr : upc_inc;
        OP_END: begin
          if (irq_pend) begin
            upc_next = IRQ_A;
            ack      = 1'b1;
          end else begin
            upc_next = FETCH_A;
          end
        end
        OP_HALT: begin
          halted_next = 1'b1;
          state_next  = PH_B;
        end
        default:     upc_next = upc_inc;
      endcase
    end
    // Interrupt requests are dropped entirely once halted.
    if (!halted)
      irq_pend_next = irq | (irq_pend & ~ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PH_A;
      upc      <= FETCH_A;
      halted   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      state    <= state_next;
      upc      <= upc_next;
      halted   <= halted_next;
      irq_pend <= irq_pend_next;
    end
  end

  assign rom_addr   = upc;
  assign phase      = (state == PH_B);
  assign ctrl_valid = phase & ~stall & ~halted & ~fault & ~reset;
  assign irq_ack    = ack & ~reset;
  assign ctrl       = ctrl_valid ? rom_data[CTRL_W+UADDR_W+2:UADDR_W+3] : '0;

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised microprogram sequencer for the 16-bit CPU. Replaces the fixed FETCH/DECODE/READ/EXEC state walk with a microprogram counter (uPC) driving a synchronous micro-ROM.
- Microwords carry their own next-address control, so instructions use variable-length micro-sequences.
- Supports conditional micro-branches, a memory-wait stall, pending-interrupt vectoring, fault vectoring and a sticky halt.
- Sits between the instruction register (instr) and the datapath control decode, which consumes ctrl.

Parameters:
- INSTR_W, 16: instruction width; must be >= 16.
- UADDR_W, 8: micro-address width.
- CTRL_W, 24: width of the datapath control field passed through to ctrl.
- FETCH_ADDR, 2: micro-address of the fetch routine.
- IRQ_VECTOR, 1: micro-address of the interrupt entry routine.
- FAULT_VECTOR, 0: micro-address of the fault routine.
- HALT_INSTR, 16'hFE00: instruction value that halts the core.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- reset, input, 1: reset, synchronous, active-high.
- instr, input, INSTR_W: current instruction register contents.
- cond_in, input, 1: condition result from the flags unit for CJUMP.
- stall, input, 1: memory wait; freezes the sequencer in phase B.
- irq, input, 1: interrupt request pulse.
- fault, input, 1: fault request.
- rom_addr, output, UADDR_W: micro-ROM address; equals upc.
- rom_data, input, CTRL_W+UADDR_W+3: micro-ROM read data, valid one cycle after the address.
- ctrl, output, CTRL_W: control field, rom_data[top CTRL_W bits]; forced to 0 when ctrl_valid=0.
- ctrl_valid, output, 1: ctrl strobe window.
- upc, output, UADDR_W: current microprogram counter.
- phase, output, 1: 0 = A (ROM access), 1 = B (execute).
- irq_ack, output, 1: one-cycle pulse when the IRQ vector is taken.
- halted, output, 1: sticky halt flag.

Behaviour:
- Microword fields:
  - naddr = rom_data[UADDR_W-1:0].
  - seqop = rom_data[UADDR_W+2:UADDR_W].
  - ctrl field = remaining top bits.
- Each microstep is 2 cycles:
  - Phase A: rom_addr=upc is presented.
  - Phase B: rom_data is valid; ctrl_valid = phase & ~stall & ~halted & ~fault (combinational). The next upc is computed and loaded at the end of phase B, and phase returns to A.
- seqop encoding:
  - 0 NEXT: upc+1.
  - 1 JUMP: naddr.
  - 2 DISPATCH: naddr+opcode.
  - 3 CJUMP: naddr if cond_in, else upc+1.
  - 4 END: FETCH_ADDR, or IRQ_VECTOR if irq_pend.
  - 5 HALT: set halted.
  - 6–7: treated as NEXT.
- Micro-address arithmetic is modulo 2^UADDR_W; upc+1 at all-ones wraps to 0.
- Opcode extraction:
  - If instr[INSTR_W-1]=0: opcode = {4'b0, instr[INSTR_W-2:INSTR_W-3]}.
  - Otherwise: opcode = instr[INSTR_W-2:INSTR_W-7] (6 bits), zero-extended to UADDR_W.
- DISPATCH with instr==HALT_INSTR behaves as HALT instead of dispatching.
- irq_pend register:
  - Next value = irq | (irq_pend & ~irq_ack); irq coinciding with irq_ack keeps irq_pend=1.
  - irq_ack=1 for exactly the cycle in which END loads IRQ_VECTOR.
- Priority per cycle: reset > halted > fault > stall > normal.
- halted: upc and phase hold, ctrl_valid=0, and irq and fault are ignored. Only reset clears it.
- fault, in either phase: next cycle upc=FAULT_VECTOR and phase=A. irq_pend is retained.
- stall:
  - Only has effect in phase B. Holds upc and phase and suppresses ctrl_valid. irq still accumulates into irq_pend.
  - stall in phase A is ignored; phase still advances to B.
- Reset values: upc=FETCH_ADDR, phase=0, irq_pend=0, irq_ack=0, halted=0, ctrl_valid=0, ctrl=0. Reset asserted mid-microstep aborts the microstep immediately with no strobe.
- Latency: from reset deassert, the first ctrl_valid occurs in the 2nd cycle. An uninterrupted microstep rate is 1 per 2 cycles.

Test Plan:
- Reset then NEXT chain at 2,3,4 → rom_addr sequence 2,2,3,3,4,4; ctrl_valid high on cycles 2,4,6 only; ctrl=0 on other cycles.
- DISPATCH with naddr=64, instr=16'h4000 (short op 2) → upc=66. With naddr=64, instr=16'h8C00 (long op 6) → upc=70.
- CJUMP naddr=0x20 at upc=0x10: cond_in=1 → upc=0x20; cond_in=0 → upc=0x11. JUMP from upc=0xFF with NEXT → wraps to 0x00.
- irq pulse during a 3-cycle stall in phase B, then END → no strobe during the stall; upc=IRQ_VECTOR (1); irq_ack high 1 cycle; irq_pend cleared afterwards. END with no pending irq → upc=2.
- fault asserted in phase B at upc=0x30 → ctrl_valid=0 that cycle; next cycle upc=0, phase=A.
- DISPATCH with instr=16'hFE00 → halted=1 and upc frozen. Subsequent irq/fault have no effect. reset → upc=2, halted=0.
